// File: rtl/bus_irq_controller.sv
// Memory-mapped interrupt controller: latches peripheral requests, masks them, and
// raises one fixed-priority interrupt to the processor with a per-source ack back.
module bus_irq_controller #(
    parameter int unsigned NUM_SOURCES = 4,
    parameter logic [7:0]  BASE_ADDR   = 8'hE0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    inout  wire  [7:0]             BUS_DATA,
    input  logic [7:0]             BUS_ADDR,
    input  logic                   BUS_WE,
    input  logic [NUM_SOURCES-1:0] IRQ_SRC,
    output logic                   IRQ_RAISE,
    input  logic                   IRQ_ACK,
    output logic [NUM_SOURCES-1:0] SRC_ACK
);

    typedef enum logic [1:0] {StIdle, StRaise, StHold} state_e;

    state_e state_q, state_d;

    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] mask_q, mask_d;
    logic [NUM_SOURCES-1:0] mode_q, mode_d;
    logic [NUM_SOURCES-1:0] prev_q;
    logic [2:0]             active_q, active_d;
    logic [7:0]             rd_data_q, rd_data_d;
    logic                   rd_oe_q, rd_oe_d;

    logic [7:0]             offset;
    logic                   in_window;
    logic                   wr_pending, wr_mask, wr_mode;
    logic [NUM_SOURCES-1:0] wr_bits;
    logic [NUM_SOURCES-1:0] active_oh, set_vec, w1c_vec, ack_vec, pending_sw, req;
    logic [2:0]             winner;
    logic                   any_req, take_ack, cancel;

    // Subtraction keeps the window correct even for an unaligned base address.
    assign offset     = BUS_ADDR - BASE_ADDR;
    assign in_window  = (offset[7:2] == 6'd0);
    assign wr_pending = BUS_WE && in_window && (offset[1:0] == 2'd0);
    assign wr_mask    = BUS_WE && in_window && (offset[1:0] == 2'd1);
    assign wr_mode    = BUS_WE && in_window && (offset[1:0] == 2'd3);
    assign wr_bits    = BUS_DATA[NUM_SOURCES-1:0];

    if (NUM_SOURCES < 8) begin : g_unused_hi
        logic unused_bus_hi;
        assign unused_bus_hi = ^BUS_DATA[7:NUM_SOURCES];
    end

    assign active_oh = NUM_SOURCES'(1) << active_q;
    assign set_vec   = IRQ_SRC & (mode_q | ~prev_q);
    assign w1c_vec   = wr_pending ? wr_bits : '0;
    assign take_ack  = (state_q == StRaise) && IRQ_ACK;
    assign ack_vec   = take_ack ? active_oh : '0;

    // Set always wins over a same-cycle W1C or ack clear.
    assign pending_sw = (pending_q & ~w1c_vec) | set_vec;
    assign pending_d  = (pending_q & ~w1c_vec & ~ack_vec) | set_vec;
    assign mask_d     = wr_mask ? wr_bits : mask_q;
    assign mode_d     = wr_mode ? wr_bits : mode_q;

    // Software withdrawing the active request is seen in the same cycle as the write.
    assign cancel  = ~|(pending_sw & mask_d & active_oh);
    assign req     = pending_q & mask_q;
    assign any_req = |req;

    always_comb begin
        winner = '0;
        for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = 3'(i);
            end
        end
    end

    assign active_d = (state_q == StIdle && any_req) ? winner : active_q;

    always_comb begin
        rd_data_d = 8'h00;
        unique case (offset[1:0])
            2'd0: rd_data_d = 8'(pending_q);
            2'd1: rd_data_d = 8'(mask_q);
            2'd2: rd_data_d = {(state_q == StRaise), 4'b0000, active_q};
            2'd3: rd_data_d = 8'(mode_q);
            default: rd_data_d = 8'h00;
        endcase
    end

    assign rd_oe_d  = !BUS_WE && in_window;
    assign BUS_DATA = rd_oe_q ? rd_data_q : 8'hzz;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StRaise;
            StRaise: begin
                if (take_ack) begin
                    state_d = StHold;
                end else if (cancel) begin
                    state_d = StIdle;
                end
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        IRQ_RAISE = (state_q == StRaise);
        SRC_ACK   = (state_q == StHold) ? active_oh : '0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            prev_q    <= '0;
            active_q  <= '0;
            rd_data_q <= '0;
            rd_oe_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            prev_q    <= IRQ_SRC;
            active_q  <= active_d;
            rd_data_q <= rd_data_d;
            rd_oe_q   <= rd_oe_d;
        end
    end

endmodule

// File: tb/tb_bus_irq_controller.sv
// Bench for bus_irq_controller: directed scenarios plus random traffic, all compared
// against a cycle-level behavioural model of pending/mask/mode and the service phase.
module tb_bus_irq_controller;

    localparam int         N    = 4;
    localparam logic [7:0] BASE = 8'hE0;

    logic         clk = 1'b0;
    logic         rst_n;
    wire  [7:0]   bus_data;
    logic [7:0]   bus_addr, drv_data;
    logic         bus_we, drv_en;
    logic [N-1:0] irq_src, src_ack;
    logic         irq_raise, irq_ack;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: phase 0 = idle, 1 = interrupt raised, 2 = ack hold cycle.
    logic [N-1:0] m_pend, m_mask, m_mode, m_prev;
    int           m_phase, m_cur;
    bit           m_rd_valid;
    logic [7:0]   m_rd_val;

    assign bus_data = drv_en ? drv_data : 8'hzz;

    bus_irq_controller #(
        .NUM_SOURCES(N),
        .BASE_ADDR  (BASE)
    ) dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .BUS_DATA (bus_data),
        .BUS_ADDR (bus_addr),
        .BUS_WE   (bus_we),
        .IRQ_SRC  (irq_src),
        .IRQ_RAISE(irq_raise),
        .IRQ_ACK  (irq_ack),
        .SRC_ACK  (src_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_mode = '0; m_prev = '0;
        m_phase = 0; m_cur = 0; m_rd_valid = 1'b0; m_rd_val = 8'h00;
    endtask

    task automatic model_step();
        logic [7:0]   off;
        logic [N-1:0] set_v, w1c, ackclr, mask_n, mode_n, pend_sw;
        int           phase_n, cur_n;
        off = bus_addr - BASE;
        case (off[1:0])
            2'd0:    m_rd_val = 8'(m_pend);
            2'd1:    m_rd_val = 8'(m_mask);
            2'd2:    m_rd_val = {(m_phase == 1), 4'b0000, 3'(m_cur)};
            default: m_rd_val = 8'(m_mode);
        endcase
        m_rd_valid = !bus_we && (off < 8'd4);
        for (int i = 0; i < N; i++) begin
            set_v[i] = m_mode[i] ? irq_src[i] : (irq_src[i] & ~m_prev[i]);
        end
        w1c     = (bus_we && off == 8'd0) ? drv_data[N-1:0] : '0;
        mask_n  = (bus_we && off == 8'd1) ? drv_data[N-1:0] : m_mask;
        mode_n  = (bus_we && off == 8'd3) ? drv_data[N-1:0] : m_mode;
        pend_sw = (m_pend & ~w1c) | set_v;
        ackclr  = '0;
        phase_n = m_phase;
        cur_n   = m_cur;
        if (m_phase == 0) begin
            for (int i = 0; i < N; i++) begin
                if (phase_n == 0 && m_pend[i] && m_mask[i]) begin
                    phase_n = 1;
                    cur_n   = i;
                end
            end
        end else if (m_phase == 1) begin
            if (irq_ack) begin
                phase_n = 2;
                ackclr[m_cur] = 1'b1;
            end else if (!pend_sw[m_cur] || !mask_n[m_cur]) begin
                phase_n = 0;
            end
        end else begin
            phase_n = 0;
        end
        m_pend  = (m_pend & ~w1c & ~ackclr) | set_v;
        m_mask  = mask_n;
        m_mode  = mode_n;
        m_prev  = irq_src;
        m_phase = phase_n;
        m_cur   = cur_n;
    endtask

    // One clock: model follows the edge, outputs are compared 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("irq_raise", 8'(irq_raise), 8'(m_phase == 1));
        check("src_ack", 8'(src_ack), (m_phase == 2) ? 8'(1 << m_cur) : 8'h00);
        if (m_rd_valid) check("bus_read", bus_data, m_rd_val);
    endtask

    task automatic bus_write(input logic [1:0] reg_off, input logic [7:0] data);
        bus_addr = BASE + 8'(reg_off);
        bus_we   = 1'b1;
        drv_en   = 1'b1;
        drv_data = data;
        tick();
        bus_we   = 1'b0;
        drv_en   = 1'b0;
        bus_addr = 8'h00;
    endtask

    // Trailing idle cycle lets the controller release the bus before any write.
    task automatic bus_read(input logic [1:0] reg_off, output logic [7:0] data);
        bus_addr = BASE + 8'(reg_off);
        bus_we   = 1'b0;
        tick();
        data     = bus_data;
        bus_addr = 8'h00;
        tick();
    endtask

    task automatic pulse_src(input int idx);
        irq_src[idx] = 1'b1;
        tick();
        irq_src[idx] = 1'b0;
        tick();
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        rst_n = 1'b0; bus_addr = 8'h00; bus_we = 1'b0; drv_en = 1'b0; drv_data = 8'h00;
        irq_src = '1; irq_ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_raise", 8'(irq_raise), 8'h00);
        check("rst_src_ack", 8'(src_ack), 8'h00);
        irq_src = '0;
        rst_n   = 1'b1;
        for (int r = 0; r < 4; r++) begin
            bus_read(2'(r), d);
            check("rst_reg", d, 8'h00);
        end

        // Edge mode, single source: 2-cycle latency, vector, ack pulse.
        bus_write(2'd1, 8'h01);
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        tick();
        check("edge_raise", 8'(irq_raise), 8'h01);
        bus_read(2'd2, d);
        check("edge_vector", d, 8'h80);
        ack_pulse();
        check("edge_src_ack", 8'(src_ack), 8'h01);
        check("edge_hold_low", 8'(irq_raise), 8'h00);
        tick();
        bus_read(2'd0, d);
        check("edge_pending", d, 8'h00);

        // Priority: simultaneous arrivals on sources 3 and 1.
        bus_write(2'd1, 8'h0F);
        irq_src = 4'b1010;
        tick();
        irq_src = 4'b0000;
        tick();
        bus_read(2'd2, d);
        check("prio_vec1", d, 8'h81);
        ack_pulse();
        check("prio_ack1", 8'(src_ack), 8'h02);
        tick();
        tick();
        check("prio_reraise", 8'(irq_raise), 8'h01);
        bus_read(2'd2, d);
        check("prio_vec3", d, 8'h83);
        ack_pulse();
        check("prio_ack3", 8'(src_ack), 8'h08);
        tick();

        // Software withdraws source 2 before ack; masked source 1 stays silent.
        pulse_src(2);
        check("w1c_raised", 8'(irq_raise), 8'h01);
        bus_write(2'd0, 8'h04);
        check("w1c_drop", 8'(irq_raise), 8'h00);
        repeat (2) tick();
        bus_write(2'd1, 8'h0D);
        pulse_src(1);
        repeat (4) tick();
        check("masked_quiet", 8'(irq_raise), 8'h00);
        bus_read(2'd0, d);
        check("masked_pending", d, 8'h02);
        bus_write(2'd0, 8'h02);

        // Level mode re-raises straight after hold; edge mode does not.
        bus_write(2'd3, 8'h01);
        bus_write(2'd1, 8'h01);
        irq_src[0] = 1'b1;
        tick();
        tick();
        check("level_raise", 8'(irq_raise), 8'h01);
        ack_pulse();
        check("level_ack", 8'(src_ack), 8'h01);
        tick();
        check("level_gap", 8'(irq_raise), 8'h00);
        tick();
        check("level_reraise", 8'(irq_raise), 8'h01);
        ack_pulse();
        irq_src[0] = 1'b0;
        tick();
        bus_write(2'd0, 8'h01);
        repeat (3) tick();
        bus_write(2'd3, 8'h00);
        irq_src[0] = 1'b1;
        tick();
        tick();
        check("edge2_raise", 8'(irq_raise), 8'h01);
        ack_pulse();
        repeat (4) tick();
        check("edge2_no_reraise", 8'(irq_raise), 8'h00);
        irq_src[0] = 1'b0;
        tick();

        // Same-cycle edge and W1C: set wins.
        irq_src[0] = 1'b1;
        bus_write(2'd0, 8'h01);
        bus_read(2'd0, d);
        check("collision_pending", d, 8'h01);
        check("collision_raise", 8'(irq_raise), 8'h01);

        // Asynchronous reset during service.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_raise", 8'(irq_raise), 8'h00);
        check("async_rst_ack", 8'(src_ack), 8'h00);
        model_reset();
        irq_src = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Random traffic against the model.
        bus_write(2'd1, 8'h0F);
        for (int c = 0; c < 3000; c++) begin
            int r;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) irq_src[i] = ~irq_src[i];
            end
            irq_ack  = (m_phase == 1) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            bus_we   = 1'b0;
            drv_en   = 1'b0;
            bus_addr = 8'h00;
            r = int'($urandom_range(15));
            if (r < 2 && !m_rd_valid) begin
                bus_we   = 1'b1;
                drv_en   = 1'b1;
                bus_addr = BASE + 8'($urandom_range(3));
                drv_data = 8'($urandom);
            end else if (r < 5) begin
                bus_addr = BASE + 8'($urandom_range(5)) - 8'd1;
            end
            tick();
        end
        irq_ack = 1'b0;
        bus_we  = 1'b0;
        drv_en  = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
